// File: rtl/pipe_latch_skid_if.sv
// ---------------------------------------------------------------------------
// pipe_latch_skid_if
// Handshake bundle for one pipeline latch stage: upstream beat in, downstream
// beat out.
//   in_valid / in_ready        upstream handshake
//   in_data / in_overflow      NUM_FIELDS*DATA_W packed fields + sideband flag
//   out_valid / out_ready      downstream handshake
//   out_data / out_overflow    registered fields + sideband flag
// Modports:
//   slave  - the latch stage itself (consumes in_*, produces out_*)
//   master - the environment around it (drives in_*, consumes out_*)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface pipe_latch_skid_if #(
   parameter int DATA_W     = 32,
   parameter int NUM_FIELDS = 3
);
   localparam int W = DATA_W * NUM_FIELDS;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         in_overflow;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic         out_overflow;

   modport slave (
      input  in_valid, in_data, in_overflow, out_ready,
      output in_ready, out_valid, out_data, out_overflow
   );

   modport master (
      output in_valid, in_data, in_overflow, out_ready,
      input  in_ready, out_valid, out_data, out_overflow
   );
endinterface

// File: rtl/pipe_latch_skid.sv
// ---------------------------------------------------------------------------
// pipe_latch_skid
// Pipeline latch stage with a two-entry (main + skid) buffer. All state is
// updated on the FALLING edge of clk. in_ready is decoded purely from
// registered state, so there is no combinational path out_ready -> in_ready;
// the skid entry absorbs the one beat that arrives while the stage discovers
// a downstream stall.
//
// Ports:
//   clk          stage clock (falling-edge active)
//   clr          synchronous active-high reset, highest priority
//   flush        synchronous squash; main IR <- NOP_IR, rest cleared
//   bus          pipe_latch_skid_if.slave (in_*/out_* handshake and data)
//   stall_count  16-bit saturating stall counter (only with macro below)
//
// Optional feature: define LATCH_STALL_CNT_EN to add the stall_count output.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module pipe_latch_skid #(
   parameter int                DATA_W     = 32,
   parameter int                NUM_FIELDS = 3,
   // value placed in the IR field (field 0) on reset or flush
   parameter logic [DATA_W-1:0] NOP_IR     = '0
) (
   input  logic                   clk,
   input  logic                   clr,
   input  logic                   flush,
   pipe_latch_skid_if.slave       bus
`ifdef LATCH_STALL_CNT_EN
   ,
   output logic [15:0]            stall_count
`endif
);

   localparam int W = DATA_W * NUM_FIELDS;
   // Reset/flush image of the main entry: NOP in the IR field, zeros above.
   localparam logic [W-1:0] RST_WORD = W'(NOP_IR);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_FULL  = 2'd1,
      S_SKID  = 2'd2
   } state_t;

   state_t       state_q;
   logic [W-1:0] main_data_q;
   logic         main_ovf_q;
   logic [W-1:0] skid_data_q;
   logic         skid_ovf_q;
   // Handshake outputs are kept as flops alongside the state so they are
   // glitch-free and independent of out_ready.
   logic         in_ready_q;
   logic         out_valid_q;

   logic         xfer_in;
   logic         xfer_out;

   assign xfer_in  = bus.in_valid && in_ready_q;
   assign xfer_out = out_valid_q  && bus.out_ready;

   // ------------------------------------------------------------------------
   // Stage FSM and storage
   // ------------------------------------------------------------------------
   always_ff @(negedge clk) begin
      if (clr) begin
         state_q     <= S_EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         main_data_q <= RST_WORD;
         main_ovf_q  <= 1'b0;
         skid_data_q <= '0;
         skid_ovf_q  <= 1'b0;
      end else if (flush) begin
         // Squash both entries; any beat offered on this edge is dropped
         // because no load path is taken.
         state_q     <= S_EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         main_data_q <= RST_WORD;
         main_ovf_q  <= 1'b0;
         skid_data_q <= '0;
         skid_ovf_q  <= 1'b0;
      end else begin
         case (state_q)
            S_EMPTY: begin
               if (xfer_in) begin
                  main_data_q <= bus.in_data;
                  main_ovf_q  <= bus.in_overflow;
                  state_q     <= S_FULL;
                  out_valid_q <= 1'b1;
                  in_ready_q  <= 1'b1;
               end
            end
            S_FULL: begin
               if (xfer_in && xfer_out) begin
                  // pass-through: replace the departing beat
                  main_data_q <= bus.in_data;
                  main_ovf_q  <= bus.in_overflow;
               end else if (xfer_in) begin
                  // downstream stalled: park the new beat in skid
                  skid_data_q <= bus.in_data;
                  skid_ovf_q  <= bus.in_overflow;
                  state_q     <= S_SKID;
                  in_ready_q  <= 1'b0;
               end else if (xfer_out) begin
                  state_q     <= S_EMPTY;
                  out_valid_q <= 1'b0;
               end
            end
            S_SKID: begin
               // in_ready is low here, so only the drain path exists
               if (xfer_out) begin
                  main_data_q <= skid_data_q;
                  main_ovf_q  <= skid_ovf_q;
                  state_q     <= S_FULL;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q     <= S_EMPTY;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready     = in_ready_q;
   assign bus.out_valid    = out_valid_q;
   assign bus.out_data     = main_data_q;
   assign bus.out_overflow = main_ovf_q;

`ifdef LATCH_STALL_CNT_EN
   // ------------------------------------------------------------------------
   // Downstream stall counter: counts edges with a presented but unaccepted
   // beat. Saturates; only clr clears it so flushes do not lose history.
   // ------------------------------------------------------------------------
   logic [15:0] stall_cnt_q;
   logic [15:0] stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (out_valid_q && !bus.out_ready && (stall_cnt_q != 16'hFFFF))
         stall_cnt_d = stall_cnt_q + 16'd1;
   end

   always_ff @(negedge clk) begin
      if (clr) stall_cnt_q <= '0;
      else     stall_cnt_q <= stall_cnt_d;
   end

   assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_latch_skid.sv
`timescale 1ns/1ps
module tb_pipe_latch_skid;
   localparam int          DW  = 32;
   localparam int          NF  = 3;
   localparam int          W   = DW * NF;
   localparam logic [31:0] NOP = 32'hDEAD_0013;
   localparam logic [W-1:0] RST_WORD = {64'h0, NOP};

   typedef struct packed {
      logic [W-1:0] data;
      logic         ovf;
   } beat_t;

   logic clk = 1'b0;
   logic clr, flush;
   int   checks = 0;
   int   errors = 0;
   beat_t exp_q[$];

   pipe_latch_skid_if #(.DATA_W(DW), .NUM_FIELDS(NF)) bus ();

`ifdef LATCH_STALL_CNT_EN
   logic [15:0] stall_count;
`endif

   pipe_latch_skid #(.DATA_W(DW), .NUM_FIELDS(NF), .NOP_IR(NOP)) dut (
      .clk   (clk),
      .clr   (clr),
      .flush (flush),
      .bus   (bus)
`ifdef LATCH_STALL_CNT_EN
      ,
      .stall_count (stall_count)
`endif
   );

   // state updates on negedge; bench drives at posedge+1, samples before negedge
   always #5 clk = ~clk;

   function automatic logic [W-1:0] mk(input logic [31:0] ir);
      return {ir ^ 32'h5A5A_0000, ir + 32'h100, ir};
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: a downstream transfer happens on the coming negedge whenever
   // out_valid && out_ready with no clr/flush; compare against the scoreboard.
   initial begin
      forever begin
         @(posedge clk); #2;
         if (!clr && !flush && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_beat: got %0h expected none", bus.out_data);
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               chk("beat_data", 128'(bus.out_data), 128'(e.data));
               chk("beat_ovf", 128'(bus.out_overflow), 128'(e.ovf));
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic send(input logic [31:0] ir, input logic ovf);
      bit done = 1'b0;
      for (int k = 0; k < 20 && !done; k++) begin
         @(posedge clk); #1;
         bus.in_valid    = 1'b1;
         bus.in_data     = mk(ir);
         bus.in_overflow = ovf;
         if (bus.in_ready) begin
            exp_q.push_back('{data: mk(ir), ovf: ovf});
            done = 1'b1;
         end
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL send_timeout: got no accept expected accept ir=%0h", ir);
      end
   endtask

   task automatic idle();
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      bus.out_ready = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #3;
         if (exp_q.size() == 0 && !bus.out_valid) break;
      end
      chk("drain_empty", 128'(exp_q.size()), 128'(0));
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_out_valid"}, 128'(bus.out_valid), 128'(0));
      chk({tag, "_in_ready"}, 128'(bus.in_ready), 128'(1));
      chk({tag, "_out_data"}, 128'(bus.out_data), 128'(RST_WORD));
      chk({tag, "_out_ovf"}, 128'(bus.out_overflow), 128'(0));
   endtask

   initial begin
      clr = 1'b1; flush = 1'b0;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.in_overflow = 1'b0;
      bus.out_ready = 1'b0;

      // reset held two falling edges
      repeat (3) @(posedge clk);
      #1 clr = 1'b0;
      chk_reset_vals("reset");
`ifdef LATCH_STALL_CNT_EN
      chk("reset_stall", 128'(stall_count), 128'(0));
`endif

      // streaming IR 1..8, one per cycle, visible one edge after acceptance
      bus.out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk); #1;
         bus.in_valid    = 1'b1;
         bus.in_data     = mk(32'(i));
         bus.in_overflow = i[0];
         chk("stream_ready", 128'(bus.in_ready), 128'(1));
         exp_q.push_back('{data: mk(32'(i)), ovf: i[0]});
         if (i > 1) begin
            chk("stream_valid", 128'(bus.out_valid), 128'(1));
            chk("stream_ir", 128'(bus.out_data[31:0]), 128'(i - 1));
         end
      end
      idle();
      chk("stream_last_ir", 128'(bus.out_data[31:0]), 128'(8));
      drain();

      // stall: A, B accepted, C held upstream while skid is occupied
      bus.out_ready = 1'b0;
      send(32'hA, 1'b1);
      send(32'hB, 1'b0);
      @(posedge clk); #1;
      bus.in_data = mk(32'hC);
      chk("skid_in_ready", 128'(bus.in_ready), 128'(0));
      chk("skid_hidden", 128'(bus.out_data[31:0]), 128'(32'hA));
      @(posedge clk); #1;
      chk("skid_in_ready2", 128'(bus.in_ready), 128'(0));
      chk("skid_hidden2", 128'(bus.out_data[31:0]), 128'(32'hA));
      bus.out_ready = 1'b1;
      send(32'hC, 1'b1);
      idle();
      drain();

      // flush while in SKID with a beat D offered
      bus.out_ready = 1'b0;
      send(32'hD1, 1'b1);
      send(32'hD2, 1'b1);
      @(posedge clk); #1;
      chk("pre_flush_skid", 128'(bus.in_ready), 128'(0));
      bus.in_data = mk(32'hD); flush = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      flush = 1'b0; bus.in_valid = 1'b0;
      chk_reset_vals("flush_skid");
      bus.out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1 chk("empty_holds", 128'(bus.out_data), 128'(RST_WORD));

      // flush while FULL with in_ready high: offered beat must be discarded
      bus.out_ready = 1'b0;
      send(32'hE1, 1'b0);
      @(posedge clk); #1;
      bus.in_valid = 1'b1; bus.in_data = mk(32'hE2); flush = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      flush = 1'b0; bus.in_valid = 1'b0;
      chk_reset_vals("flush_full");
      drain();

      // clr and flush together while in SKID
      bus.out_ready = 1'b0;
      send(32'hF1, 1'b1);
      send(32'hF2, 1'b1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0; clr = 1'b1; flush = 1'b1;
      exp_q.delete();
      @(posedge clk); #1;
      clr = 1'b0; flush = 1'b0;
      chk_reset_vals("clr_skid");
`ifdef LATCH_STALL_CNT_EN
      chk("clr_stall", 128'(stall_count), 128'(0));
`endif
      bus.out_ready = 1'b1;
      send(32'h61, 1'b0);
      send(32'h62, 1'b1);
      idle();
      drain();

`ifdef LATCH_STALL_CNT_EN
      // stall counter: counts stalled edges, saturates without wrapping
      @(posedge clk); #1 clr = 1'b1;
      @(posedge clk); #1 clr = 1'b0;
      bus.out_ready = 1'b0;
      send(32'h77, 1'b0);
      idle();
      repeat (3) @(posedge clk);
      #1 chk("stall_small", 128'(stall_count), 128'(3));
      repeat (70000) @(posedge clk);
      #1 chk("stall_sat", 128'(stall_count), 128'(16'hFFFF));
      @(posedge clk); #1 chk("stall_nowrap", 128'(stall_count), 128'(16'hFFFF));
      drain();
`endif

      chk("final_queue", 128'(exp_q.size()), 128'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/pipe_latch_skid.md
PIPE_LATCH_SKID -- requirements
Module: pipe_latch_skid

Interface
REQ-001 Parameter DATA_W, default 32, width of one pipeline field.
REQ-002 Parameter NUM_FIELDS, default 3, number of packed fields; field 0 (bits DATA_W-1:0) is the instruction register.
REQ-003 Parameter NOP_IR, default 32'h0000_0000, value loaded into field 0 on reset or flush.
REQ-004 clk  input  1  stage clock; all state updates on the falling edge.
REQ-005 clr  input  1  reset; synchronous, active-high.
REQ-006 flush  input  1  squash the stage contents; synchronous.
REQ-007 in_valid  input  1  upstream beat present.
REQ-008 in_ready  output  1  stage accepts a beat this cycle.
REQ-009 in_data  input  NUM_FIELDS*DATA_W  packed fields (IR, ALU result, data...).
REQ-010 in_overflow  input  1  sideband flag travelling with the beat.
REQ-011 out_valid  output  1  downstream beat present.
REQ-012 out_ready  input  1  downstream accepts this cycle.
REQ-013 out_data  output  NUM_FIELDS*DATA_W  registered packed fields.
REQ-014 out_overflow  output  1  registered sideband flag.

Function
REQ-015 Storage SHALL be two entries: main (drives out_data/out_overflow directly) and skid; each entry holds data plus overflow.
REQ-016 States SHALL be EMPTY (no entry valid), FULL (main valid), SKID (main and skid valid).
REQ-017 in_ready SHALL equal (state != SKID), decoded from registered state only, with no combinational path from out_ready.
REQ-018 out_valid SHALL equal (state != EMPTY).
REQ-019 A transfer in SHALL occur when in_valid && in_ready; a transfer out when out_valid && out_ready.
REQ-020 EMPTY: transfer in loads main and moves to FULL; otherwise stay.
REQ-021 FULL: in and out together loads main and stays FULL; in only loads skid and moves to SKID; out only moves to EMPTY; neither holds.
REQ-022 SKID: transfer out copies skid into main and moves to FULL; otherwise hold both entries.
REQ-023 Latency SHALL be one falling edge from accepted input to out_valid; throughput SHALL be one beat per cycle while out_ready stays high.
REQ-024 Beat order SHALL be preserved; no beat is dropped or duplicated except by flush.
REQ-025 flush SHALL override all handshakes: next state EMPTY; main field 0 loaded with NOP_IR, other main fields and overflow cleared to 0; a beat presented on the flush edge is discarded.
REQ-026 While EMPTY, out_data SHALL hold its last loaded value; consumers qualify with out_valid.
REQ-027 Skid contents SHALL not be observable on outputs until promoted to main.

Reset
REQ-028 clr high at a falling edge SHALL force state EMPTY, out_valid=0, in_ready=1, out_data field 0 = NOP_IR, other fields 0, out_overflow=0, skid cleared.
REQ-029 clr SHALL take priority over flush and all handshakes, including reset asserted mid-SKID.

Configuration
REQ-030 Macro LATCH_STALL_CNT_EN defined: add output stall_count (16 bits), incrementing on each edge where out_valid && !out_ready, saturating at 16'hFFFF, cleared by clr only (not flush).
REQ-031 Macro undefined: stall_count port and counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-032 clr held 2 cycles -> out_valid=0, in_ready=1, out_data field 0 = NOP_IR, out_overflow=0.
REQ-033 Stream beats with IR 1..8, out_ready=1 throughout -> outputs IR 1..8 in order, one per cycle, 1-edge latency.
REQ-034 Beats IR=A,B,C with out_ready=0 from A's arrival -> in_ready drops after B enters skid, C held upstream; out_ready=1 -> A,B,C emerge in order.
REQ-035 State SKID, flush=1 with in_valid=1, IR=D -> next edge out_valid=0, in_ready=1, field 0 = NOP_IR; D never appears.
REQ-036 State SKID, clr and flush asserted together -> reset values of REQ-028; with LATCH_STALL_CNT_EN, stall_count=0.
REQ-037 LATCH_STALL_CNT_EN, out_valid=1, out_ready=0 for 70000 cycles -> stall_count=16'hFFFF, no wrap.
